// File: rtl/axi_prewrapper_ctrl.sv
// Sequencer for the AXI pre-wrapper datapath: decodes host opcode/config and
// drives register-file enables, DUT vector addressing, DUT clock enable and scan dumps.
module axi_prewrapper_ctrl #(
  parameter int unsigned p_sc_nbr     = 16,
  parameter int unsigned p_in_words   = 8,
  parameter int unsigned p_out_words  = 8,
  parameter int unsigned p_scan_depth = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ctrl_opcode,
  input  logic [31:0]              ctrl_config,
  output logic [31:0]              ctrl_state,
  output logic [p_sc_nbr+4:0]      rf_ren,
  output logic [p_sc_nbr+4:0]      rf_wen,
  output logic [31:0]              dut_input_vec_rdaddr,
  output logic [31:0]              dut_output_vec_wraddr,
  output logic                     dut_input_vec_en,
  output logic                     dut_input_vec_mode,
  output logic                     dut_output_vec_en,
  output logic                     dut_output_vec_mode,
  output logic [32*p_sc_nbr-1:0]   dft_output_data_wraddr,
  output logic                     dut_clk_en,
  output logic                     scan_en
);
  localparam int unsigned RF_W  = p_sc_nbr + 5;
  localparam int unsigned K_W   = 16;
  localparam int unsigned DFT_W = 32 * p_sc_nbr;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_LOAD = 4'd1,
    S_RUN  = 4'd2,
    S_CAPT = 4'd3,
    S_SCAN = 4'd4,
    S_DONE = 4'd15
  } state_t;

  state_t           r_state;
  logic [K_W-1:0]   r_k;
  logic             r_err;
  logic [3:0]       r_last_op;

  state_t           w_state_nx;
  logic [K_W-1:0]   w_k_nx;
  logic             w_err_nx;
  logic [3:0]       w_last_nx;
  logic [3:0]       w_op;
  logic [K_W-1:0]   w_run_n;
  logic [7:0]       w_scan_raw;
  logic [K_W-1:0]   w_scan_d;
  logic             w_unused;

  logic [RF_W-1:0]  w_rf_wen;
  logic [31:0]      w_rdaddr;
  logic [31:0]      w_wraddr;
  logic             w_in_en;
  logic             w_in_mode;
  logic             w_out_en;
  logic             w_out_mode;
  logic [DFT_W-1:0] w_dft;
  logic             w_clk_en;
  logic             w_scan_en;

  assign w_op       = ctrl_opcode[3:0];
  assign w_run_n    = ctrl_config[15:0];
  assign w_scan_raw = ctrl_config[23:16];
  assign w_unused   = ^{ctrl_opcode[31:4], ctrl_config[31:24]};

  // Out-of-range scan depth saturates to the full chain length
  assign w_scan_d = (w_scan_raw == 8'd0 || 32'(w_scan_raw) > p_scan_depth)
                    ? K_W'(p_scan_depth) : K_W'(w_scan_raw);

  // Next state, counter and status
  always_comb begin
    w_state_nx = r_state;
    w_k_nx     = r_k;
    w_err_nx   = r_err;
    w_last_nx  = r_last_op;
    unique case (r_state)
      S_IDLE: begin
        if (w_op != 4'd0) begin
          w_last_nx = w_op;
          w_k_nx    = '0;
          w_err_nx  = 1'b0;
          unique case (w_op)
            4'd1:    w_state_nx = S_LOAD;
            4'd2:    w_state_nx = S_RUN;
            4'd3:    w_state_nx = S_CAPT;
            4'd4:    w_state_nx = S_SCAN;
            default: begin
              w_state_nx = S_DONE;
              w_err_nx   = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        w_k_nx = r_k + K_W'(1);
        if (r_k == K_W'(p_in_words - 1)) begin
          w_state_nx = S_DONE;
          w_k_nx     = '0;
        end
      end
      S_RUN: begin
        w_k_nx = r_k + K_W'(1);
        if (w_run_n == '0 || r_k == w_run_n - K_W'(1)) begin
          w_state_nx = S_DONE;
          w_k_nx     = '0;
        end
      end
      S_CAPT: begin
        w_k_nx = r_k + K_W'(1);
        if (r_k == K_W'(p_out_words)) begin
          w_state_nx = S_DONE;
          w_k_nx     = '0;
        end
      end
      S_SCAN: begin
        w_k_nx = r_k + K_W'(1);
        if (r_k == w_scan_d - K_W'(1)) begin
          w_state_nx = S_DONE;
          w_k_nx     = '0;
        end
      end
      S_DONE: begin
        if (w_op == 4'd0) w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_k_nx     = '0;
      end
    endcase
  end

  // Moore output decode of the upcoming state, so outputs can be registered
  always_comb begin
    w_rf_wen   = RF_W'(5'h0F);
    w_rdaddr   = '0;
    w_wraddr   = '0;
    w_in_en    = 1'b0;
    w_in_mode  = 1'b0;
    w_out_en   = 1'b0;
    w_out_mode = 1'b0;
    w_dft      = '0;
    w_clk_en   = 1'b0;
    w_scan_en  = 1'b0;
    if (w_state_nx != S_IDLE && w_state_nx != S_DONE) w_rf_wen = RF_W'(2'b10);
    unique case (w_state_nx)
      S_LOAD: begin
        w_in_en   = 1'b1;
        w_in_mode = 1'b1;
        w_rdaddr  = 32'(w_k_nx);
      end
      S_RUN:  w_clk_en = (w_run_n != '0);
      S_CAPT: begin
        w_out_en = 1'b1;
        if (w_k_nx != '0) begin
          w_out_mode  = 1'b1;
          w_wraddr    = 32'(w_k_nx - K_W'(1));
          w_rf_wen[4] = 1'b1;
        end
      end
      S_SCAN: begin
        w_scan_en           = 1'b1;
        w_dft               = {p_sc_nbr{32'(w_k_nx)}};
        w_rf_wen[RF_W-1:5] = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state                <= S_IDLE;
      r_k                    <= '0;
      r_err                  <= 1'b0;
      r_last_op              <= 4'd0;
      ctrl_state             <= '0;
      rf_ren                 <= '1;
      rf_wen                 <= RF_W'(5'h0F);
      dut_input_vec_rdaddr   <= '0;
      dut_output_vec_wraddr  <= '0;
      dut_input_vec_en       <= 1'b0;
      dut_input_vec_mode     <= 1'b0;
      dut_output_vec_en      <= 1'b0;
      dut_output_vec_mode    <= 1'b0;
      dft_output_data_wraddr <= '0;
      dut_clk_en             <= 1'b0;
      scan_en                <= 1'b0;
    end else begin
      r_state                <= w_state_nx;
      r_k                    <= w_k_nx;
      r_err                  <= w_err_nx;
      r_last_op              <= w_last_nx;
      ctrl_state             <= {w_k_nx, 7'd0, w_err_nx, w_last_nx, 4'(w_state_nx)};
      rf_ren                 <= '1;
      rf_wen                 <= w_rf_wen;
      dut_input_vec_rdaddr   <= w_rdaddr;
      dut_output_vec_wraddr  <= w_wraddr;
      dut_input_vec_en       <= w_in_en;
      dut_input_vec_mode     <= w_in_mode;
      dut_output_vec_en      <= w_out_en;
      dut_output_vec_mode    <= w_out_mode;
      dft_output_data_wraddr <= w_dft;
      dut_clk_en             <= w_clk_en;
      scan_en                <= w_scan_en;
    end
  end

endmodule

// File: tb/tb_axi_prewrapper_ctrl.sv
// Randomized bench for axi_prewrapper_ctrl: per-operation expected output
// sequences built from opcode/config rules, checked every cycle, plus literal pins.
module tb_axi_prewrapper_ctrl;
  logic         clk;
  logic         reset;
  logic [31:0]  ctrl_opcode;
  logic [31:0]  ctrl_config;
  logic [31:0]  ctrl_state;
  logic [20:0]  rf_ren;
  logic [20:0]  rf_wen;
  logic [31:0]  dut_input_vec_rdaddr;
  logic [31:0]  dut_output_vec_wraddr;
  logic         dut_input_vec_en;
  logic         dut_input_vec_mode;
  logic         dut_output_vec_en;
  logic         dut_output_vec_mode;
  logic [511:0] dft_output_data_wraddr;
  logic         dut_clk_en;
  logic         scan_en;

  axi_prewrapper_ctrl dut (
    .clk                    (clk),
    .reset                  (reset),
    .ctrl_opcode            (ctrl_opcode),
    .ctrl_config            (ctrl_config),
    .ctrl_state             (ctrl_state),
    .rf_ren                 (rf_ren),
    .rf_wen                 (rf_wen),
    .dut_input_vec_rdaddr   (dut_input_vec_rdaddr),
    .dut_output_vec_wraddr  (dut_output_vec_wraddr),
    .dut_input_vec_en       (dut_input_vec_en),
    .dut_input_vec_mode     (dut_input_vec_mode),
    .dut_output_vec_en      (dut_output_vec_en),
    .dut_output_vec_mode    (dut_output_vec_mode),
    .dft_output_data_wraddr (dft_output_data_wraddr),
    .dut_clk_en             (dut_clk_en),
    .scan_en                (scan_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // f = {in_en, in_mode, out_en, out_mode, clk_en, scan_en}
  typedef struct packed {
    logic [31:0]  st;
    logic [20:0]  ren;
    logic [20:0]  wen;
    logic [31:0]  rd;
    logic [31:0]  wr;
    logic [511:0] dft;
    logic [5:0]   f;
  } exp_t;

  int n_vec = 0;
  int n_mis = 0;
  int c_ien = 0, c_cen = 0, c_sen = 0, c_wen4 = 0, c_snap = 0, c_snapwen = 0;
  int c_lock = 0, c_scanbad = 0, c_any = 0;
  logic [31:0] last_scan = '0;
  logic        m_err = 1'b0;
  logic [3:0]  m_last = 4'd0;

  function automatic exp_t exp_rest(input logic [3:0] code, input logic err, input logic [3:0] last);
    exp_t e;
    e     = '0;
    e.st  = {16'd0, 7'd0, err, last, code};
    e.ren = '1;
    e.wen = 21'h0F;
    return e;
  endfunction

  // Expected outputs for cycle t of an operation, straight from the opcode rules
  function automatic exp_t exp_active(input logic [3:0] o, input int t, input logic [31:0] cfg);
    exp_t e;
    e     = '0;
    e.st  = {16'(t), 7'd0, 1'b0, o, o};
    e.ren = '1;
    e.wen = 21'h02;
    case (o)
      4'd1: begin e.f = 6'b110000; e.rd = 32'(t); end
      4'd2: e.f[1] = (cfg[15:0] != 16'd0);
      4'd3: begin
        e.f[3] = 1'b1;
        if (t > 0) begin e.f[2] = 1'b1; e.wr = 32'(t - 1); e.wen[4] = 1'b1; end
      end
      4'd4: begin
        e.f[0]     = 1'b1;
        e.wen[20:5] = '1;
        for (int i = 0; i < 16; i++) e.dft[32*i +: 32] = 32'(t);
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic int active_len(input logic [3:0] o, input logic [31:0] cfg);
    int d;
    case (o)
      4'd1: return 8;
      4'd2: return (cfg[15:0] == 16'd0) ? 1 : int'(cfg[15:0]);
      4'd3: return 9;
      4'd4: begin
        d = int'(cfg[23:16]);
        return (d == 0 || d > 64) ? 64 : d;
      end
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  // Advance one cycle, then compare the DUT against the expectation for it
  task automatic step(input exp_t e);
    exp_t a;
    @(posedge clk);
    #2;
    a.st  = ctrl_state;
    a.ren = rf_ren;
    a.wen = rf_wen;
    a.rd  = dut_input_vec_rdaddr;
    a.wr  = dut_output_vec_wraddr;
    a.dft = dft_output_data_wraddr;
    a.f   = {dut_input_vec_en, dut_input_vec_mode, dut_output_vec_en,
             dut_output_vec_mode, dut_clk_en, scan_en};
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL cycle t=%0t: got st=%h ren=%h wen=%h rd=%h wr=%h f=%b dft=%h ; want st=%h ren=%h wen=%h rd=%h wr=%h f=%b dft=%h",
               $time, a.st, a.ren, a.wen, a.rd, a.wr, a.f, a.dft[63:0],
               e.st, e.ren, e.wen, e.rd, e.wr, e.f, e.dft[63:0]);
    end
    if (a.f[5]) c_ien++;
    if (a.f[1]) c_cen++;
    if (a.f[0]) begin
      c_sen++;
      last_scan = a.dft[31:0];
      if (a.wen[20:5] != 16'hFFFF || a.dft != {16{a.dft[31:0]}}) c_scanbad++;
    end
    if (a.wen[4]) c_wen4++;
    if (a.f[3] && !a.f[2]) begin
      c_snap++;
      if (a.wen[4]) c_snapwen++;
    end
    if (a.f[5] && (a.wen[0] || a.wen[2] || a.wen[3])) c_lock++;
    if (a.f[5] || a.f[3] || a.f[1] || a.f[0]) c_any++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      ctrl_opcode = $urandom() & 32'hFFFF_FFF0;
      step(exp_rest(4'd0, m_err, m_last));
    end
  endtask

  // Issue one host operation from IDLE; abort_k >= 0 asserts reset while k==abort_k
  task automatic run_op(input logic [31:0] op, input logic [31:0] cfg, input int hold,
                        input int abort_k, output logic [31:0] fd);
    logic [3:0] o;
    int a;
    o  = op[3:0];
    fd = '0;
    ctrl_opcode = op;
    ctrl_config = cfg;
    if (o == 4'd0) begin
      step(exp_rest(4'd0, m_err, m_last));
      return;
    end
    m_last = o;
    m_err  = (o > 4'd4);
    a = active_len(o, cfg);
    for (int t = 0; t < a; t++) begin
      if (abort_k >= 0 && t == abort_k + 1) begin
        reset = 1'b0;
        ctrl_opcode = '0;
        m_err  = 1'b0;
        m_last = 4'd0;
        step(exp_rest(4'd0, 1'b0, 4'd0));
        step(exp_rest(4'd0, 1'b0, 4'd0));
        reset = 1'b1;
        step(exp_rest(4'd0, 1'b0, 4'd0));
        return;
      end
      step(exp_active(o, t, cfg));
    end
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) ctrl_opcode = ($urandom() & 32'hFFFF_FFF0) | 32'($urandom_range(1, 15));
      step(exp_rest(4'hF, m_err, m_last));
      if (h == 0) fd = ctrl_state;
    end
    ctrl_opcode = $urandom() & 32'hFFFF_FFF0;
    step(exp_rest(4'd0, m_err, m_last));
  endtask

  initial begin
    logic [31:0] fd;
    logic [3:0]  o;
    int b0, b1, b2, b3;
    reset = 1'b0;
    ctrl_opcode = '0;
    ctrl_config = '0;
    for (int i = 0; i < 3; i++) step(exp_rest(4'd0, 1'b0, 4'd0));
    reset = 1'b1;
    step(exp_rest(4'd0, 1'b0, 4'd0));
    chk("reset_state", 64'(ctrl_state), 64'h0);
    chk("reset_rf_wen", 64'(rf_wen), 64'h0F);
    chk("reset_rf_ren", 64'(rf_ren), 64'h1F_FFFF);

    // LOAD and host acknowledge
    b0 = c_ien;
    run_op(32'h1, 32'h0, 2, -1, fd);
    chk("load_done_state", 64'(fd), 64'h1F);
    chk("load_ack_state", 64'(ctrl_state), 64'h10);
    chk("load_in_en_count", 64'(c_ien - b0), 64'd8);
    chk("load_lockout", 64'(c_lock), 64'd0);

    // RUN with N=5 and N=0
    b0 = c_cen;
    run_op(32'h2, 32'h5, 1, -1, fd);
    chk("run5_pulses", 64'(c_cen - b0), 64'd5);
    b0 = c_cen;
    run_op(32'h2, 32'h0, 0, -1, fd);
    chk("run0_pulses", 64'(c_cen - b0), 64'd0);
    chk("run0_done_state", 64'(fd), 64'h2F);

    // CAPT
    b0 = c_wen4; b1 = c_snap; b2 = c_snapwen;
    run_op(32'h3, 32'h0, 1, -1, fd);
    chk("capt_wen4_count", 64'(c_wen4 - b0), 64'd8);
    chk("capt_snap_count", 64'(c_snap - b1), 64'd1);
    chk("capt_snap_wen4", 64'(c_snapwen - b2), 64'd0);

    // SCAN depth 3 and saturated depth 200
    b0 = c_sen;
    run_op(32'h4, 32'h0003_0000, 0, -1, fd);
    chk("scan3_count", 64'(c_sen - b0), 64'd3);
    chk("scan3_last_addr", 64'(last_scan), 64'd2);
    b0 = c_sen;
    run_op(32'h4, 32'h00C8_0000, 1, -1, fd);
    chk("scan200_count", 64'(c_sen - b0), 64'd64);
    chk("scan200_last_addr", 64'(last_scan), 64'd63);
    chk("scan_banks", 64'(c_scanbad), 64'd0);

    // Illegal opcode
    b3 = c_any;
    run_op(32'h9, 32'h0000_0005, 2, -1, fd);
    chk("illegal_done_state", 64'(fd), 64'h19F);
    chk("illegal_no_enables", 64'(c_any - b3), 64'd0);

    // Reset asserted for two cycles while SCAN is at k=10
    run_op(32'h4, 32'h0, 0, 10, fd);
    chk("abort_state", 64'(ctrl_state), 64'h0);
    chk("abort_scan_en", 64'(scan_en), 64'h0);
    chk("abort_rf_wen", 64'(rf_wen), 64'h0F);
    chk("abort_rf_ren", 64'(rf_ren), 64'h1F_FFFF);

    // Longest RUN count must not wrap early
    b0 = c_cen;
    run_op(32'h2, 32'h0000_FFFF, 0, -1, fd);
    chk("run_max_pulses", 64'(c_cen - b0), 64'd65535);

    // Randomized operation mix with random upper opcode bits and ack delays
    for (int n = 0; n < 40; n++) begin
      b0 = $urandom_range(0, 7);
      o  = (b0 <= 4) ? 4'(b0) : 4'($urandom_range(5, 15));
      idle_cycles($urandom_range(0, 3));
      run_op(($urandom() & 32'hFFFF_FFF0) | 32'(o),
             ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 12)),
             $urandom_range(0, 3), -1, fd);
    end
    chk("final_lockout", 64'(c_lock), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
